// File: rtl/alu_mc.sv
// alu_mc: multi-cycle execution unit with a valid/ready handshake.
// Simple ops finish one cycle after acceptance. Unsigned mul/mulhu/divu/remu
// iterate one bit per cycle (shift-add / restoring division). The result and
// its zero flag are held until the consumer takes them.
module alu_mc #(
  parameter int WIDTH = 32,
  parameter int OPW   = 5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = $clog2(WIDTH + 1);

  localparam logic [OPW-1:0] OP_NOP   = OPW'(0);
  localparam logic [OPW-1:0] OP_LUI   = OPW'(1);
  localparam logic [OPW-1:0] OP_AUIPC = OPW'(2);
  localparam logic [OPW-1:0] OP_ADD   = OPW'(3);
  localparam logic [OPW-1:0] OP_SUB   = OPW'(4);
  localparam logic [OPW-1:0] OP_AND   = OPW'(5);
  localparam logic [OPW-1:0] OP_OR    = OPW'(6);
  localparam logic [OPW-1:0] OP_XOR   = OPW'(7);
  localparam logic [OPW-1:0] OP_SLL   = OPW'(8);
  localparam logic [OPW-1:0] OP_SRL   = OPW'(9);
  localparam logic [OPW-1:0] OP_SRA   = OPW'(10);
  localparam logic [OPW-1:0] OP_SLT   = OPW'(11);
  localparam logic [OPW-1:0] OP_SLTU  = OPW'(12);
  localparam logic [OPW-1:0] OP_MUL   = OPW'(13);
  localparam logic [OPW-1:0] OP_MULHU = OPW'(14);
  localparam logic [OPW-1:0] OP_DIVU  = OPW'(15);
  localparam logic [OPW-1:0] OP_REMU  = OPW'(16);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   result_q;
  logic               zero_q;
  logic               out_valid_q;
  logic               busy_q;
  logic [CW-1:0]      cnt_q;

  // Captured operation; not reset since it is only read while iterating.
  logic [OPW-1:0]     op_q;
  logic [WIDTH-1:0]   opnd_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_d;

  logic               accept;
  logic               is_iter;
  logic               is_mul;
  logic [WIDTH-1:0]   simple_res;
  logic [WIDTH-1:0]   iter_res;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;

  function automatic logic [WIDTH-1:0] simple_op(
    input logic [OPW-1:0]   o,
    input logic [WIDTH-1:0] x,
    input logic [WIDTH-1:0] y
  );
    logic [SHW-1:0] sh;
    logic [WIDTH-1:0] r;
    sh = y[SHW-1:0];
    case (o)
      OP_LUI, OP_AUIPC, OP_ADD: r = x + y;
      OP_SUB:  r = x - y;
      OP_AND:  r = x & y;
      OP_OR:   r = x | y;
      OP_XOR:  r = x ^ y;
      OP_SLL:  r = x << sh;
      OP_SRL:  r = x >> sh;
      OP_SRA:  r = $signed(x) >>> sh;
      OP_SLT:  r = {{(WIDTH-1){1'b0}}, ($signed(x) < $signed(y))};
      OP_SLTU: r = {{(WIDTH-1){1'b0}}, (x < y)};
      default: r = '0;
    endcase
    return r;
  endfunction

  assign in_ready   = (state_q == S_IDLE);
  assign accept     = in_valid & in_ready;
  assign is_mul     = (op == OP_MUL) || (op == OP_MULHU);
  assign is_iter    = is_mul || (op == OP_DIVU) || (op == OP_REMU);
  assign simple_res = simple_op(op, a, b);

  assign out_valid  = out_valid_q;
  assign result     = result_q;
  assign zero       = zero_q;
  assign busy       = busy_q;

  // One iteration step: shift-add for multiply, restoring step for divide.
  // acc holds {high, low}: product halves, or {remainder, quotient}.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    acc_d     = acc_q;
    if ((op_q == OP_MUL) || (op_q == OP_MULHU)) begin
      if (acc_q[0]) acc_d = {mul_sum, acc_q[WIDTH-1:1]};
      else          acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
    end else begin
      // Divisor 0 never borrows, giving all-ones quotient and remainder = a.
      if (!div_diff[WIDTH]) acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      else                  acc_d = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end
    case (op_q)
      OP_MUL, OP_DIVU: iter_res = acc_d[WIDTH-1:0];
      default:         iter_res = acc_d[2*WIDTH-1:WIDTH];
    endcase
  end

  // Capture operands on acceptance and advance the iteration while busy.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q   <= op;
      opnd_q <= is_mul ? a : b;
      acc_q  <= is_mul ? {{WIDTH{1'b0}}, b} : {{WIDTH{1'b0}}, a};
    end else if (state_q == S_CALC) begin
      acc_q  <= acc_d;
    end
  end

  // Control FSM with registered result, zero, out_valid and busy.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      result_q    <= '0;
      zero_q      <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            if (is_iter) begin
              state_q <= S_CALC;
              cnt_q   <= CW'(WIDTH);
              busy_q  <= 1'b1;
            end else begin
              state_q     <= S_DONE;
              out_valid_q <= 1'b1;
              if (op != OP_NOP) begin
                result_q <= simple_res;
                zero_q   <= (simple_res == '0);
              end else begin
                zero_q   <= (result_q == '0);
              end
            end
          end
        end
        S_CALC: begin
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q     <= S_DONE;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
            result_q    <= iter_res;
            zero_q      <= (iter_res == '0);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed table-driven bench for alu_mc plus hand-written
// sequences for backpressure and reset abort.
module tb_alu_mc;

  logic        clk;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        busy;

  int total = 0;
  int bad   = 0;

  alu_mc #(.WIDTH(32), .OPW(5)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t tbl[20];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  // Issue one op, wait for out_valid (bounded), check latency/result/zero, then hand over.
  task automatic run_op(input string nm, input logic [4:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] exp, input int exp_lat);
    int lat;
    int busy_n;
    @(negedge clk);
    chk({nm, " in_ready"}, {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    #1;
    in_valid = 1'b0; op = 5'($urandom); a = $urandom; b = $urandom;
    lat = 0; busy_n = 0;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      if (busy) busy_n++;
      if (out_valid) break;
    end
    chk({nm, " latency"}, lat, exp_lat);
    if (exp_lat > 1) chk({nm, " busy cycles"}, busy_n, exp_lat - 1);
    chk({nm, " result"}, result, exp);
    chk({nm, " zero"}, {31'd0, zero}, {31'd0, (exp == 32'd0)});
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk({nm, " handover"}, {30'd0, out_valid, in_ready}, 32'd1);
  endtask

  initial begin
    tbl[0]  = '{5'd3,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1};
    tbl[1]  = '{5'd4,  32'h00000005, 32'h00000005, 32'h00000000, 1};
    tbl[2]  = '{5'd10, 32'h80000000, 32'h0000003F, 32'hFFFFFFFF, 1};
    tbl[3]  = '{5'd12, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 1};
    tbl[4]  = '{5'd11, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1};
    tbl[5]  = '{5'd5,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1};
    tbl[6]  = '{5'd6,  32'hF0F0F0F0, 32'h0F0F0000, 32'hFFFFF0F0, 1};
    tbl[7]  = '{5'd7,  32'hAAAAAAAA, 32'hFFFFFFFF, 32'h55555555, 1};
    tbl[8]  = '{5'd8,  32'h00000001, 32'h00000024, 32'h00000010, 1};
    tbl[9]  = '{5'd9,  32'h80000000, 32'h0000001F, 32'h00000001, 1};
    tbl[10] = '{5'd1,  32'h00000000, 32'h12345000, 32'h12345000, 1};
    tbl[11] = '{5'd2,  32'h00001000, 32'hFFFFF000, 32'h00000000, 1};
    tbl[12] = '{5'd17, 32'h00000005, 32'h00000005, 32'h00000000, 1};
    tbl[13] = '{5'd14, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33};
    tbl[14] = '{5'd13, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 33};
    tbl[15] = '{5'd15, 32'd100,      32'd7,        32'd14,       33};
    tbl[16] = '{5'd16, 32'd100,      32'd7,        32'd2,        33};
    tbl[17] = '{5'd15, 32'd9,        32'd0,        32'hFFFFFFFF, 33};
    tbl[18] = '{5'd16, 32'd9,        32'd0,        32'd9,        33};
    tbl[19] = '{5'd14, 32'h00010000, 32'h00010000, 32'h00000001, 33};

    rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk("reset result", result, 32'd0);
    chk("reset flags", {28'd0, zero, out_valid, in_ready, busy}, 32'b1010);
    rstn = 1'b1;

    for (int i = 0; i < 20; i++)
      run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp, tbl[i].lat);

    // Backpressure: result held, new requests ignored while out_ready is low.
    @(negedge clk);
    in_valid = 1'b1; op = 5'd3; a = 32'd2; b = 32'd2;
    @(negedge clk);
    op = 5'd4; a = 32'd100; b = 32'd1;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("bp hold%0d", i), {result[29:0], out_valid, in_ready}, {30'd4, 1'b1, 1'b0});
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("bp release", {30'd0, out_valid, in_ready}, 32'd1);
    run_op("nop", 5'd0, 32'h11111111, 32'h22222222, 32'd4, 1);

    // Abort: asynchronous reset 10 cycles into a divide.
    @(negedge clk);
    in_valid = 1'b1; op = 5'd15; a = 32'd100; b = 32'd7;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("abort busy before", {31'd0, busy}, 32'd1);
    #2;
    rstn = 1'b0;
    #1;
    chk("abort result", result, 32'd0);
    chk("abort flags", {28'd0, zero, out_valid, in_ready, busy}, 32'b1010);
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    run_op("post abort add", 5'd3, 32'd2, 32'd3, 32'd5, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
